mem_arbiter: RTL and testbench

- Shares the single memory/cache port between two requesters: instruction fetch (I) and the load/store path (D).
- Sits between controller/datapath and memory, and drives the command/busy handshake with the memory.
- Round-robin arbitration when both request.
- A busy watchdog ensures a stuck memory cannot hang the core.

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / load-store) arbiter for a single memory port.
// Round-robin on ties, one-cycle command pulse, busy watchdog aborts stuck accesses.
module mem_arbiter #(
    parameter int NBITS   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_req,
    input  logic [NBITS-1:0] i_addr,
    output logic             i_done,
    output logic [NBITS-1:0] i_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [NBITS-1:0] d_addr,
    input  logic [NBITS-1:0] d_wdata,
    output logic             d_done,
    output logic [NBITS-1:0] d_rdata,
    output logic             err,
    output logic             mem_read,
    output logic             mem_write,
    output logic [NBITS-1:0] mem_addr,
    output logic [NBITS-1:0] mem_wdata,
    input  logic             mem_busy,
    input  logic [NBITS-1:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    state_t        state;
    owner_t        owner;
    owner_t        last;
    logic          we;
    logic [CW-1:0] cnt;

    logic i_elig, d_elig, grant_any, grant_d;

    // A requester whose done is visible this cycle is not eligible, so a held
    // request is not re-issued on the strength of the completed access.
    always_comb begin
        i_elig    = i_req && !i_done;
        d_elig    = d_req && !d_done;
        grant_any = i_elig || d_elig;
        grant_d   = d_elig && (!i_elig || (last == OWN_I));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= OWN_I;
            last      <= OWN_I;
            we        <= 1'b0;
            cnt       <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            err       <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            err       <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner     <= grant_d ? OWN_D : OWN_I;
                        if (i_elig && d_elig)
                            last <= grant_d ? OWN_D : OWN_I;
                        we        <= grant_d && d_we;
                        mem_addr  <= grant_d ? d_addr : i_addr;
                        mem_wdata <= grant_d ? d_wdata : '0;
                        mem_read  <= !(grant_d && d_we);
                        mem_write <= grant_d && d_we;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (!mem_busy) begin
                        if (owner == OWN_I) begin
                            i_rdata <= mem_rdata;
                            i_done  <= 1'b1;
                        end else begin
                            if (!we)
                                d_rdata <= mem_rdata;
                            d_done <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (cnt >= CW'(TIMEOUT - 1)) begin
                        // Watchdog expiry: complete the access with err and zeroed data.
                        cnt <= CW'(TIMEOUT);
                        err <= 1'b1;
                        if (owner == OWN_I) begin
                            i_rdata <= '0;
                            i_done  <= 1'b1;
                        end else begin
                            d_rdata <= '0;
                            d_done  <= 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// checked against a transaction-schedule reference model.
module tb_mem_arbiter;

    localparam int NBITS   = 8;
    localparam int TIMEOUT = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             i_req = 1'b0;
    logic [NBITS-1:0] i_addr = '0;
    logic             i_done;
    logic [NBITS-1:0] i_rdata;
    logic             d_req = 1'b0;
    logic             d_we = 1'b0;
    logic [NBITS-1:0] d_addr = '0;
    logic [NBITS-1:0] d_wdata = '0;
    logic             d_done;
    logic [NBITS-1:0] d_rdata;
    logic             err;
    logic             mem_read;
    logic             mem_write;
    logic [NBITS-1:0] mem_addr;
    logic [NBITS-1:0] mem_wdata;
    logic             mem_busy = 1'b0;
    logic [NBITS-1:0] mem_rdata = '0;

    always #5 clock = ~clock;

    mem_arbiter #(.NBITS(NBITS), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .err(err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_busy(mem_busy), .mem_rdata(mem_rdata)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: each access is a scheduled transaction (grant cycle g,
    // planned busy count b); command at g+1, done at g+3+b or g+2+TIMEOUT.
    bit         m_active = 0;
    bit         m_owner_d = 0;
    bit         m_last_d = 0;
    bit         m_we = 0;
    int         m_g = 0, m_b = 0, m_done_t = 0;
    logic [7:0] m_cap = '0;
    bit         wdata_known = 1;
    int         plan_b = -1;
    int         force_rdata = -1;

    bit         e_i_done = 0, e_d_done = 0, e_err = 0, e_mem_read = 0, e_mem_write = 0;
    logic [7:0] e_i_rdata = '0, e_d_rdata = '0, e_mem_addr = '0, e_mem_wdata = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_eval();
        bit ie, de, gd, tmo;
        bit n_id, n_dd, n_er, n_rd, n_wr;
        logic [7:0] n_ir, n_dr, n_ad, n_wd;
        if (reset) begin
            m_active = 0; m_last_d = 0; wdata_known = 1;
            e_i_done = 0; e_d_done = 0; e_err = 0; e_mem_read = 0; e_mem_write = 0;
            e_i_rdata = '0; e_d_rdata = '0; e_mem_addr = '0; e_mem_wdata = '0;
            return;
        end
        n_id = 0; n_dd = 0; n_er = 0; n_rd = 0; n_wr = 0;
        n_ir = e_i_rdata; n_dr = e_d_rdata; n_ad = e_mem_addr; n_wd = e_mem_wdata;
        if (m_active && cyc >= m_done_t) m_active = 0;
        if (m_active) begin
            tmo = (m_b >= TIMEOUT);
            if (!tmo && cyc == m_g + 2 + m_b) m_cap = mem_rdata;
            if (cyc + 1 == m_done_t) begin
                n_er = tmo;
                if (m_owner_d) begin
                    n_dd = 1;
                    if (tmo) n_dr = '0;
                    else if (!m_we) n_dr = m_cap;
                end else begin
                    n_id = 1;
                    n_ir = tmo ? 8'h00 : m_cap;
                end
            end
        end else begin
            ie = i_req && !e_i_done;
            de = d_req && !e_d_done;
            if (ie || de) begin
                gd = de && (!ie || !m_last_d);
                if (ie && de) m_last_d = gd;
                m_owner_d = gd;
                m_we = gd && d_we;
                m_g = cyc;
                if (plan_b >= 0) m_b = plan_b;
                else m_b = ($urandom_range(0, 9) == 0) ? TIMEOUT + 1 : int'($urandom_range(0, 3));
                m_done_t = (m_b >= TIMEOUT) ? cyc + 2 + TIMEOUT : cyc + 3 + m_b;
                n_ad = gd ? d_addr : i_addr;
                n_wd = gd ? d_wdata : e_mem_wdata;
                wdata_known = gd;
                n_rd = !m_we;
                n_wr = m_we;
                m_active = 1;
            end
        end
        e_i_done = n_id; e_d_done = n_dd; e_err = n_er; e_mem_read = n_rd; e_mem_write = n_wr;
        e_i_rdata = n_ir; e_d_rdata = n_dr; e_mem_addr = n_ad; e_mem_wdata = n_wd;
    endtask

    task automatic tick();
        model_eval();
        @(posedge clock);
        #1;
        cyc++;
        check("i_done", i_done, e_i_done);
        check("d_done", d_done, e_d_done);
        check("err", err, e_err);
        check("i_rdata", i_rdata, e_i_rdata);
        check("d_rdata", d_rdata, e_d_rdata);
        check("mem_read", mem_read, e_mem_read);
        check("mem_write", mem_write, e_mem_write);
        check("mem_addr", mem_addr, e_mem_addr);
        if (wdata_known) check("mem_wdata", mem_wdata, e_mem_wdata);
        // memory model: busy for the planned cycles of the WAIT phase
        if (m_active && cyc >= m_g + 2 &&
            ((m_b >= TIMEOUT) ? (cyc < m_done_t) : (cyc < m_done_t - 1)))
            mem_busy = 1'b1;
        else
            mem_busy = 1'b0;
        mem_rdata = (force_rdata >= 0) ? 8'(force_rdata) : 8'($urandom);
    endtask

    initial begin
        int k, hit;
        // reset state
        reset = 1'b1;
        tick(); tick();
        check("reset_mem_read", mem_read, 0);
        check("reset_i_rdata", i_rdata, 0);
        reset = 1'b0;
        tick();

        // single fetch, no busy
        plan_b = 0; force_rdata = 8'hA5;
        i_addr = 8'h10; i_req = 1'b1;
        tick();
        check("fetch_mem_read", mem_read, 1);
        check("fetch_mem_addr", mem_addr, 8'h10);
        tick(); tick();
        check("fetch_i_done", i_done, 1);
        check("fetch_i_rdata", i_rdata, 8'hA5);
        check("fetch_d_done", d_done, 0);
        i_req = 1'b0;
        tick();

        // store with two busy cycles
        plan_b = 2;
        d_we = 1'b1; d_addr = 8'h20; d_wdata = 8'h3C; d_req = 1'b1;
        tick();
        check("store_mem_write", mem_write, 1);
        check("store_mem_wdata", mem_wdata, 8'h3C);
        tick(); tick(); tick(); tick();
        check("store_d_done", d_done, 1);
        check("store_d_rdata", d_rdata, 0);
        d_req = 1'b0;
        tick();

        // contention right after reset: D, I, D, I
        reset = 1'b1; tick(); reset = 1'b0;
        plan_b = 0; force_rdata = -1;
        i_addr = 8'h44; d_addr = 8'h88; d_we = 1'b1; d_wdata = 8'h77;
        i_req = 1'b1; d_req = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (j % 3 == 1) check("rr_mem_write", mem_write, ((j / 3) % 2 == 0) ? 1 : 0);
            if (j % 3 == 0) begin
                check("rr_d_done", d_done, ((j / 3) % 2 == 1) ? 1 : 0);
                check("rr_i_done", i_done, ((j / 3) % 2 == 0) ? 1 : 0);
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        tick(); tick(); tick(); tick();

        // normal load, then a load that times out
        plan_b = 0; force_rdata = 8'h5A;
        d_we = 1'b0; d_addr = 8'h30; d_req = 1'b1;
        tick(); tick(); tick();
        check("load_d_rdata", d_rdata, 8'h5A);
        d_req = 1'b0;
        tick();
        plan_b = TIMEOUT + 5;
        d_addr = 8'h31; d_req = 1'b1;
        hit = 0;
        for (k = 1; k <= 40 && hit == 0; k++) begin
            tick();
            if (d_done === 1'b1) hit = k;
        end
        check("tmo_latency", hit, 2 + TIMEOUT);
        check("tmo_err", err, 1);
        check("tmo_d_rdata", d_rdata, 0);
        d_req = 1'b0;
        tick();
        plan_b = 0; force_rdata = 8'hC3;
        i_addr = 8'h12; i_req = 1'b1;
        tick(); tick(); tick();
        check("post_tmo_i_done", i_done, 1);
        check("post_tmo_err", err, 0);
        i_req = 1'b0;
        tick();

        // reset during WAIT of a fetch
        plan_b = 6; i_addr = 8'h55; i_req = 1'b1;
        tick(); tick(); tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst_i_done", i_done, 0);
        check("rst_err", err, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_i_rdata", i_rdata, 0);
        plan_b = 0; d_we = 1'b0; d_addr = 8'h66; d_req = 1'b1;
        tick();
        check("rst_d_first", mem_addr, 8'h66);
        i_req = 1'b0;
        tick(); tick();
        d_req = 1'b0;
        tick();

        // fetch request held through its done cycle
        i_addr = 8'h70; i_req = 1'b1;
        tick(); tick(); tick();
        check("held_i_done", i_done, 1);
        tick();
        check("held_no_reissue", mem_read, 0);
        tick();
        check("held_reissue", mem_read, 1);
        tick(); tick();
        i_req = 1'b0;
        tick(); tick(); tick();

        // random traffic
        plan_b = -1; force_rdata = -1;
        for (int j = 0; j < 600; j++) begin
            i_req   = ($urandom_range(0, 3) != 0);
            d_req   = ($urandom_range(0, 2) != 0);
            d_we    = $urandom_range(0, 1) == 1;
            i_addr  = 8'($urandom);
            d_addr  = 8'($urandom);
            d_wdata = 8'($urandom);
            if ($urandom_range(0, 199) == 0) reset = 1'b1;
            tick();
            reset = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
